// File: rtl/vec_issue_queue.sv
// In-order issue queue between the scalar core and the vector datapath.
// Buffers DEPTH instructions with operands and runs one at a time through an IDLE/EXEC/ACK handshake.
module vec_issue_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inst_valid,
    input  logic [XLEN-1:0]          instruction,
    input  logic [XLEN-1:0]          rs1_data,
    input  logic [XLEN-1:0]          rs2_data,
    output logic                     vec_pro_ready,
    output logic                     issue_valid,
    output logic [XLEN-1:0]          issue_inst,
    output logic [XLEN-1:0]          issue_rs1,
    output logic [XLEN-1:0]          issue_rs2,
    input  logic                     inst_done,
    output logic                     vec_pro_ack,
    input  logic                     scalar_pro_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         retire_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

    state_t            state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [CNT_W-1:0]  retire_q;

    logic [XLEN-1:0]   inst_mem [DEPTH];
    logic [XLEN-1:0]   rs1_mem  [DEPTH];
    logic [XLEN-1:0]   rs2_mem  [DEPTH];

    logic push;
    logic pop;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign vec_pro_ready = !reset && (count_q < CW'(DEPTH));
    assign push          = inst_valid && vec_pro_ready;
    assign pop           = (state_q == EXEC) && inst_done;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            retire_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                retire_q <= retire_q + CNT_W'(1);
            end
            case (state_q)
                IDLE:    if (count_q != '0) state_q <= EXEC;
                EXEC:    if (inst_done) state_q <= ACK;
                ACK:     if (scalar_pro_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Payload storage carries no reset; the head slot cannot be overwritten while it is counted.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= instruction;
            rs1_mem[wr_ptr_q]  <= rs1_data;
            rs2_mem[wr_ptr_q]  <= rs2_data;
        end
    end

    assign issue_valid = (state_q == EXEC);
    assign vec_pro_ack = (state_q == ACK);
    assign issue_inst  = issue_valid ? inst_mem[rd_ptr_q] : '0;
    assign issue_rs1   = issue_valid ? rs1_mem[rd_ptr_q]  : '0;
    assign issue_rs2   = issue_valid ? rs2_mem[rd_ptr_q]  : '0;
    assign occupancy   = count_q;
    assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_vec_issue_queue.sv
// Scoreboard bench for vec_issue_queue: accepted entries are queued and checked in order when issued.
module tb_vec_issue_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        vec_pro_ready;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic        inst_done;
    logic        vec_pro_ack;
    logic        scalar_pro_ready;
    logic [2:0]  occupancy;
    logic [15:0] retire_cnt;

    typedef struct {
        logic [31:0] i;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] issued_log[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_retire = 0;
    logic        prev_iv = 1'b0;

    vec_issue_queue #(.XLEN(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_valid       (inst_valid),
        .instruction      (instruction),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .vec_pro_ready    (vec_pro_ready),
        .issue_valid      (issue_valid),
        .issue_inst       (issue_inst),
        .issue_rs1        (issue_rs1),
        .issue_rs2        (issue_rs2),
        .inst_done        (inst_done),
        .vec_pro_ack      (vec_pro_ack),
        .scalar_pro_ready (scalar_pro_ready),
        .occupancy        (occupancy),
        .retire_cnt       (retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // Each new issue pops the oldest accepted entry and compares the presented payload.
    always @(negedge clk) begin
        if (issue_valid && !prev_iv) begin
            n_checks++;
            issued_log.push_back(issue_inst);
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_issue: got inst=%h with no entry pending, required no issue", issue_inst);
            end else begin
                ent_t e;
                e = sb.pop_front();
                if (issue_inst !== e.i || issue_rs1 !== e.a || issue_rs2 !== e.b) begin
                    n_fail++;
                    $display("FAIL sb_issue: got %h/%h/%h required %h/%h/%h",
                             issue_inst, issue_rs1, issue_rs2, e.i, e.a, e.b);
                end
            end
        end
        prev_iv = issue_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input int budget);
        ent_t e;
        inst_valid  = 1'b1;
        instruction = i;
        rs1_data    = a;
        rs2_data    = b;
        while (!vec_pro_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!vec_pro_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL enq_timeout: inst %h never accepted, required vec_pro_ready=1", i);
        end else begin
            tick();
            e.i = i; e.a = a; e.b = b;
            sb.push_back(e);
        end
        inst_valid = 1'b0;
    endtask

    task automatic complete(input int done_dly, input int rdy_dly);
        int budget = 300;
        while (!issue_valid && budget > 0) begin
            tick();
            budget--;
        end
        if (!issue_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: issue_valid=%b, required 1", issue_valid);
        end else begin
            repeat (done_dly) tick();
            inst_done = 1'b1;
            tick();
            inst_done = 1'b0;
            n_checks++;
            if (vec_pro_ack !== 1'b1) begin
                n_fail++;
                $display("FAIL ack_after_done: vec_pro_ack=%b required 1", vec_pro_ack);
            end
            repeat (rdy_dly) tick();
            scalar_pro_ready = 1'b1;
            tick();
            scalar_pro_ready = 1'b0;
            exp_retire++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_retire = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if (vec_pro_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_ready: vec_pro_ready=%b required 0", vec_pro_ready);
        end
        n_checks++;
        if (issue_valid !== 1'b0 || vec_pro_ack !== 1'b0 || issue_inst !== 32'h0) begin
            n_fail++; $display("FAIL rst_outputs: iv=%b ack=%b inst=%h required 0/0/0", issue_valid, vec_pro_ack, issue_inst);
        end
        n_checks++;
        if (occupancy !== 3'd0 || retire_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_counts: occ=%0d ret=%0d required 0/0", occupancy, retire_cnt);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (vec_pro_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_release_ready: vec_pro_ready=%b required 1", vec_pro_ready);
        end
        exp_retire = 0;
    endtask

    task automatic test_single();
        enq(32'h0201_7057, 32'h10, 32'h4, 5);
        n_checks++;
        if (occupancy !== 3'd1 || issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_n1: occ=%0d iv=%b required 1/0", occupancy, issue_valid);
        end
        tick();
        n_checks++;
        if (issue_valid !== 1'b1 || issue_inst !== 32'h0201_7057 || issue_rs1 !== 32'h10 || issue_rs2 !== 32'h4) begin
            n_fail++; $display("FAIL single_issue: iv=%b %h/%h/%h required 1 02017057/10/4", issue_valid, issue_inst, issue_rs1, issue_rs2);
        end
        tick();
        tick();
        inst_done = 1'b1;
        tick();
        inst_done = 1'b0;
        exp_retire++;
        n_checks++;
        if (vec_pro_ack !== 1'b1 || issue_valid !== 1'b0 || issue_inst !== 32'h0) begin
            n_fail++; $display("FAIL single_ack: ack=%b iv=%b inst=%h required 1/0/0", vec_pro_ack, issue_valid, issue_inst);
        end
        n_checks++;
        if (retire_cnt !== 16'(exp_retire) || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL single_counts: ret=%0d occ=%0d required %0d/0", retire_cnt, occupancy, exp_retire);
        end
        scalar_pro_ready = 1'b1;
        tick();
        scalar_pro_ready = 1'b0;
        n_checks++;
        if (vec_pro_ack !== 1'b0 || issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: ack=%b iv=%b required 0/0", vec_pro_ack, issue_valid);
        end
    endtask

    task automatic test_full();
        for (int k = 1; k <= 4; k++) enq(32'h100 + k, 32'h200 + k, 32'h300 + k, 5);
        n_checks++;
        if (occupancy !== 3'd4 || vec_pro_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_after4: occ=%0d rdy=%b required 4/0", occupancy, vec_pro_ready);
        end
        inst_valid  = 1'b1;
        instruction = 32'h105;
        rs1_data    = 32'h205;
        rs2_data    = 32'h305;
        repeat (3) tick();
        n_checks++;
        if (occupancy !== 3'd4 || vec_pro_ready !== 1'b0 || issue_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_hold: occ=%0d rdy=%b iv=%b required 4/0/1", occupancy, vec_pro_ready, issue_valid);
        end
        inst_done = 1'b1;
        tick();
        inst_done = 1'b0;
        exp_retire++;
        n_checks++;
        if (occupancy !== 3'd3 || vec_pro_ready !== 1'b1 || vec_pro_ack !== 1'b1) begin
            n_fail++; $display("FAIL full_pop: occ=%0d rdy=%b ack=%b required 3/1/1", occupancy, vec_pro_ready, vec_pro_ack);
        end
        tick();
        sb.push_back('{32'h105, 32'h205, 32'h305});
        inst_valid = 1'b0;
        n_checks++;
        if (occupancy !== 3'd4) begin
            n_fail++; $display("FAIL full_refill: occ=%0d required 4", occupancy);
        end
        scalar_pro_ready = 1'b1;
        tick();
        scalar_pro_ready = 1'b0;
        repeat (4) complete(0, 0);
        n_checks++;
        if (retire_cnt !== 16'(exp_retire) || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL full_drain: ret=%0d occ=%0d required %0d/0", retire_cnt, occupancy, exp_retire);
        end
    endtask

    task automatic test_simul();
        enq(32'hA0, 32'hA1, 32'hA2, 5);
        enq(32'hB0, 32'hB1, 32'hB2, 5);
        n_checks++;
        if (issue_valid !== 1'b1 || occupancy !== 3'd2) begin
            n_fail++; $display("FAIL simul_pre: iv=%b occ=%0d required 1/2", issue_valid, occupancy);
        end
        inst_valid  = 1'b1;
        instruction = 32'hC0;
        rs1_data    = 32'hC1;
        rs2_data    = 32'hC2;
        inst_done   = 1'b1;
        tick();
        sb.push_back('{32'hC0, 32'hC1, 32'hC2});
        inst_valid = 1'b0;
        inst_done  = 1'b0;
        exp_retire++;
        n_checks++;
        if (occupancy !== 3'd2 || vec_pro_ack !== 1'b1) begin
            n_fail++; $display("FAIL simul_occ: occ=%0d ack=%b required 2/1", occupancy, vec_pro_ack);
        end
        scalar_pro_ready = 1'b1;
        tick();
        scalar_pro_ready = 1'b0;
        issued_log.delete();
        complete(1, 0);
        complete(0, 1);
        n_checks++;
        if (issued_log.size() != 2 || issued_log[0] !== 32'hB0 || issued_log[1] !== 32'hC0) begin
            n_fail++; $display("FAIL simul_order: got %0d issues first=%h, required B0 then C0",
                               issued_log.size(), (issued_log.size() > 0) ? issued_log[0] : 32'h0);
        end
    endtask

    task automatic test_ack_hold();
        enq(32'hD0, 32'hD1, 32'hD2, 5);
        enq(32'hE0, 32'hE1, 32'hE2, 5);
        inst_done = 1'b1;
        tick();
        inst_done = 1'b0;
        exp_retire++;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (vec_pro_ack !== 1'b1 || issue_valid !== 1'b0) begin
                n_fail++; $display("FAIL ack_hold_%0d: ack=%b iv=%b required 1/0", c, vec_pro_ack, issue_valid);
            end
            tick();
        end
        scalar_pro_ready = 1'b1;
        tick();
        scalar_pro_ready = 1'b0;
        n_checks++;
        if (vec_pro_ack !== 1'b0 || issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL ack_release: ack=%b iv=%b required 0/0", vec_pro_ack, issue_valid);
        end
        tick();
        n_checks++;
        if (issue_valid !== 1'b1 || issue_inst !== 32'hE0) begin
            n_fail++; $display("FAIL ack_next_issue: iv=%b inst=%h required 1/E0", issue_valid, issue_inst);
        end
        complete(0, 0);
    endtask

    task automatic test_stream();
        do_reset();
        issued_log.delete();
        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    enq(32'(k), 32'(k) << 4, ~32'(k), 300);
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                for (int k = 0; k < 10; k++) complete($urandom_range(0, 3), $urandom_range(0, 3));
            end
        join
        n_checks++;
        if (retire_cnt !== 16'd10 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL stream_counts: ret=%0d occ=%0d required 10/0", retire_cnt, occupancy);
        end
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (k >= issued_log.size()) begin
                n_fail++; $display("FAIL stream_order_%0d: missing issue, required %h", k, 32'(k + 1));
            end else if (issued_log[k] !== 32'(k + 1)) begin
                n_fail++; $display("FAIL stream_order_%0d: got %h required %h", k, issued_log[k], 32'(k + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        enq(32'hF1, 32'h1, 32'h2, 5);
        enq(32'hF2, 32'h3, 32'h4, 5);
        enq(32'hF3, 32'h5, 32'h6, 5);
        n_checks++;
        if (issue_valid !== 1'b1 || occupancy !== 3'd3) begin
            n_fail++; $display("FAIL mid_pre: iv=%b occ=%0d required 1/3", issue_valid, occupancy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_retire = 0;
        #1;
        n_checks++;
        if (issue_valid !== 1'b0 || vec_pro_ack !== 1'b0 || occupancy !== 3'd0 || retire_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset: iv=%b ack=%b occ=%0d ret=%0d required 0/0/0/0",
                               issue_valid, vec_pro_ack, occupancy, retire_cnt);
        end
        issued_log.delete();
        repeat (8) tick();
        n_checks++;
        if (issued_log.size() != 0 || issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_old_issue: issues=%0d iv=%b required 0/0", issued_log.size(), issue_valid);
        end
        enq(32'h77, 32'h78, 32'h79, 5);
        complete(0, 0);
        n_checks++;
        if (retire_cnt !== 16'd1 || issued_log.size() != 1) begin
            n_fail++; $display("FAIL mid_recover: ret=%0d issues=%0d required 1/1", retire_cnt, issued_log.size());
        end
    endtask

    initial begin
        reset            = 1'b1;
        inst_valid       = 1'b0;
        instruction      = '0;
        rs1_data         = '0;
        rs2_data         = '0;
        inst_done        = 1'b0;
        scalar_pro_ready = 1'b0;
        tick();
        test_reset();
        test_single();
        test_full();
        test_simul();
        test_ack_hold();
        test_stream();
        test_reset_mid();
        repeat (2) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: %0d entries never issued, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
